// File: rtl/req_encoder_queue.sv
// Sequential N-to-log2(N) request encoder with pending capture and valid/ready output slot.
// Optional `define ROUND_ROBIN_EN enables rotating-priority selection.
module req_encoder_queue #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            clr,
    input  logic            ready,
    output logic            valid,
    output logic [IDXW-1:0] idx,
    output logic [N-1:0]    pending,
    output logic            overflow
);

    logic            take;
    logic            any_cand;
    logic [N-1:0]    cand;
    logic [N-1:0]    sel_mask;
    logic [IDXW-1:0] sel;

    assign take     = !valid | ready;
    assign cand     = pending | req;
    assign any_cand = |cand;
    assign sel_mask = {{(N-1){1'b0}}, 1'b1} << sel;

`ifdef ROUND_ROBIN_EN
    logic [IDXW-1:0] ptr;

    // Search starts just past the last granted line and wraps.
    always_comb begin : rr_search
        logic found;
        int   j;
        sel   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && cand[j]) begin
                sel   = IDXW'(j);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IDXW'(N - 1);
        end else if (clr) begin
            ptr <= IDXW'(N - 1);
        end else if (take && any_cand) begin
            ptr <= sel;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand[k]) begin
                sel = IDXW'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            idx      <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            valid    <= 1'b0;
            idx      <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            // A line re-requesting while still pending means one request is lost.
            overflow <= overflow | (|(req & pending));
            if (take) begin
                if (any_cand) begin
                    idx     <= sel;
                    valid   <= 1'b1;
                    pending <= cand & ~sel_mask;
                end else begin
                    valid   <= 1'b0;
                    pending <= '0;
                end
            end else begin
                pending <= cand;
            end
        end
    end

endmodule

// File: tb/tb_req_encoder_queue.sv
// Scoreboard bench for req_encoder_queue with a set-based reference model.
// Honours `define ROUND_ROBIN_EN the same way as the design.
module tb_req_encoder_queue;

    localparam int N    = 4;
    localparam int IDXW = 2;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr   = 1'b0;
    logic            ready = 1'b0;
    logic [N-1:0]    req   = '0;
    logic            valid;
    logic [IDXW-1:0] idx;
    logic [N-1:0]    pending;
    logic            overflow;

    req_encoder_queue #(.N(N), .IDXW(IDXW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .clr      (clr),
        .ready    (ready),
        .valid    (valid),
        .idx      (idx),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            v;
        logic [IDXW-1:0] i;
        logic [N-1:0]    p;
        logic            o;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    bit   m_valid;
    int   m_idx;
    bit   m_pend[N];
    bit   m_ovf;
    int   m_ptr;

    function automatic void m_reset();
        m_valid = 0;
        m_idx   = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
        m_ovf   = 0;
        m_ptr   = N - 1;
    endfunction

    function automatic void m_step(logic [N-1:0] r, bit c, bit rd);
        bit cand[N];
        bit any;
        int s;
        if (!rst_n || c) begin
            m_reset();
            return;
        end
        for (int i = 0; i < N; i++)
            if (r[i] && m_pend[i]) m_ovf = 1;
        any = 0;
        for (int i = 0; i < N; i++) begin
            cand[i] = m_pend[i] | r[i];
            any     = any | cand[i];
        end
        if (!m_valid || rd) begin
            if (any) begin
                s = -1;
`ifdef ROUND_ROBIN_EN
                for (int k = 1; k <= N; k++)
                    if (s < 0 && cand[(m_ptr + k) % N]) s = (m_ptr + k) % N;
`else
                for (int k = 0; k < N; k++)
                    if (s < 0 && cand[k]) s = k;
`endif
                m_idx   = s;
                m_valid = 1;
                m_ptr   = s;
                cand[s] = 0;
                m_pend  = cand;
            end else begin
                m_valid = 0;
                foreach (m_pend[i]) m_pend[i] = 0;
            end
        end else begin
            m_pend = cand;
        end
    endfunction

    function automatic exp_t m_exp();
        exp_t e;
        e.v = m_valid;
        e.i = IDXW'(m_idx);
        for (int i = 0; i < N; i++) e.p[i] = m_pend[i];
        e.o = m_ovf;
        return e;
    endfunction

    // Issue one cycle of stimulus and queue the state expected after the edge.
    task automatic step(input logic [N-1:0] r, input bit c, input bit rd);
        req   = r;
        clr   = c;
        ready = rd;
        m_step(r, c, rd);
        sb.push_back(m_exp());
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({valid, idx, pending, overflow} !== '0) begin
            bad++;
            $display("FAIL %s: got v=%0b idx=%0d pend=%b ovf=%0b, want all zero",
                     name, valid, idx, pending, overflow);
        end
    endtask

    task automatic async_rst();
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        m_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if ({valid, idx, pending, overflow} !== e) begin
                    bad++;
                    $display("FAIL slot @%0t: got v=%0b idx=%0d pend=%b ovf=%0b want v=%0b idx=%0d pend=%b ovf=%0b",
                             $time, valid, idx, pending, overflow, e.v, e.i, e.p, e.o);
                end
            end
        end
    end

    initial begin : stim
        logic [N-1:0] r;
        m_reset();
        req = 4'b1111;
        repeat (2) @(posedge clk);
        #2;
        check_zero("reset_state");
        rst_n = 1'b1;

        step(4'b0110, 0, 1);
        repeat (3) step(4'b0000, 0, 1);

        step(4'b0001, 0, 0);
        step(4'b1000, 0, 0);
        step(4'b0000, 0, 0);
        repeat (3) step(4'b0000, 0, 1);

        step(4'b0001, 0, 0);
        step(4'b0100, 0, 0);
        step(4'b0100, 0, 0);
        step(4'b0000, 0, 0);
        step(4'b0000, 1, 0);
        step(4'b0000, 0, 1);

        repeat (8) step(4'b1111, 0, 1);
        step(4'b0000, 1, 1);

        step(4'b0001, 0, 0);
        step(4'b1010, 0, 0);
        async_rst();
        step(4'b1111, 0, 1);
        rst_n = 1'b1;
        step(4'b0010, 0, 1);
        step(4'b0000, 0, 1);

        for (int n = 0; n < 500; n++) begin
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) r = '0;
            if ($urandom_range(0, 149) == 0) begin
                async_rst();
                step(r, 0, 1);
                rst_n = 1'b1;
            end else begin
                step(r, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
            end
        end

        @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
